// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: FSM state encoding, bit-period
//                arithmetic and counter sizing. Used by the receiver and by
//                the companion transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // 2-bit FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } uart_state_e;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

  // Width of a counter that runs 0 .. cpb-1.
  function automatic int unsigned cnt_width(input int unsigned cpb);
    return (cpb < 2) ? 1 : $clog2(cpb);
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sync
//  Description : Two-flop synchronizer for an asynchronous single-bit input.
//                Both flops reset to 1 so an idle-high line (UART RX, push
//                buttons) reads as inactive straight out of reset.
//  Ports       : clk     - destination clock
//                rst_n   - asynchronous active-low reset
//                async_i - asynchronous input
//                sync_o  - synchronized output
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver with mid-bit sampling and a valid/ready
//                output holding register.
//  Ports       : clk       - system clock
//                rst_n     - asynchronous active-low reset
//                uart_rxd  - serial input (asynchronous, idles high)
//                rx_ready  - consumer ready
//                rx_data   - received byte, stable while rx_valid is high
//                rx_valid  - byte available, held until accepted
//                frame_err - one-cycle pulse: stop bit sampled low
//                overrun   - one-cycle pulse: byte dropped, previous unaccepted
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun
);

  // CLKS_PER_BIT must be at least 4 for the half-bit count to be meaningful.
  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = cnt_width(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  logic             rxd_sync;
  logic             rxd_prev_q;
  logic             fall_edge;

  uart_state_e      state_q;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic [7:0]       rx_data_q;
  logic             rx_valid_q;
  logic             frame_err_q;
  logic             overrun_q;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (uart_rxd),
    .sync_o  (rxd_sync)
  );

  // Extra registered copy of the synchronized line for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_prev_q <= rxd_sync;
    end
  end

  assign fall_edge = rxd_prev_q & ~rxd_sync;

  // The cycle the edge is seen is cycle 0; the counter is 0 in cycle 1, so
  // reaching HALF_BIT-1 puts the start sample at cycle HALF_BIT, and every
  // later sample lands exactly CLKS_PER_BIT cycles after the previous one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      // Accept; a delivery in the same cycle overrides this below.
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (fall_edge) begin
            state_q    <= START;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
          end
        end

        START: begin
          if (baud_cnt_q == HALF_LAST) begin
            baud_cnt_q <= '0;
            if (rxd_sync) begin
              state_q <= IDLE;   // line back high mid start bit: glitch
            end else begin
              state_q <= DATA;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (baud_cnt_q == BIT_LAST) begin
            baud_cnt_q <= '0;
            shift_q    <= {rxd_sync, shift_q[7:1]};  // LSB arrives first
            bit_cnt_q  <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        STOP: begin
          if (baud_cnt_q == BIT_LAST) begin
            baud_cnt_q <= '0;
            state_q    <= IDLE;
            if (!rxd_sync) begin
              frame_err_q <= 1'b1;
            end else if (!rx_valid_q || rx_ready) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule : uart_rx
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Byte-wide UART receiver: the receive counterpart of the MNIST top-level's `uart_txd` transmit path. It accepts 8N1 serial frames on `uart_rxd`, recovers bytes, and hands them to downstream logic over a valid/ready interface. This is the path for host-to-FPGA traffic such as image pixels and commands. It sits directly behind the pin and runs entirely in the 50 MHz system clock domain.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate.
- Derived constants:
  - `CLKS_PER_BIT = (CLK_FREQ + BAUD/2) / BAUD`, which is 434 at the defaults; must be ≥ 4.
  - `HALF_BIT = CLKS_PER_BIT / 2`, which is 217 at the defaults.
- `clk` in 1: system clock; sole clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `uart_rxd` in 1: serial line, asynchronous to `clk`; idles high.
- `rx_ready` in 1: consumer accepts the byte when `rx_valid && rx_ready`.
- `rx_data` out 8: received byte; stable while `rx_valid` is high.
- `rx_valid` out 1: byte available; held until accepted.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `overrun` out 1: one-cycle pulse when a byte completes while the previous one is still unaccepted.

## Operation
- **Input sync:** `uart_rxd` passes through a 2-flop synchronizer (both flops reset to 1), then one further registered copy for edge detection.
- **Start detect:** a falling edge is previous synced sample 1 and current 0. It is honoured only in IDLE.
- **States:** IDLE, START, DATA, STOP.
  - **IDLE → START** on a falling edge; the bit counter clears.
  - **START:** count `HALF_BIT` cycles, then sample.
    - Sample 0: go to DATA.
    - Sample 1: glitch; return to IDLE with no output.
  - **DATA:** every `CLKS_PER_BIT` cycles, sample one bit into a shift register, LSB first. After the 8th bit, go to STOP.
  - **STOP:** after `CLKS_PER_BIT` cycles, sample, then go to IDLE in the same cycle. The block does not wait for the end of the stop bit.
    - Sample 1: deliver the byte.
    - Sample 0: pulse `frame_err` and discard the byte.
    - Because edge detect needs a 1→0 transition, a line held low after a framing error starts nothing until it returns high.
- **Delivery:**
  - If `rx_valid` is 0, or the same cycle has `rx_valid && rx_ready`: load `rx_data` and set `rx_valid`.
  - Otherwise: keep the old byte and `rx_valid`, drop the new byte, and pulse `overrun`.
- **Accept:** `rx_valid && rx_ready` with no simultaneous delivery clears `rx_valid` on the next edge. `rx_data` keeps its last value.
- **Reset:**
  - Outputs: `rx_data` = 0x00, `rx_valid` = 0, `frame_err` = 0, `overrun` = 0.
  - Internal: state IDLE, counters 0, synchronizer flops 1.
  - Asserting `rst_n` mid-frame aborts the frame immediately. No partial byte is delivered after release.

## Timing
- Let cycle 0 be the first cycle the edge detector sees the falling edge. Pin-to-detector latency is 2–3 cycles.
- Sample points, relative to cycle 0:
  - Start bit: cycle `HALF_BIT` (217).
  - Data bit i: cycle `HALF_BIT + (i+1)*CLKS_PER_BIT`.
  - Stop bit: cycle `HALF_BIT + 9*CLKS_PER_BIT` (4123).
- `rx_valid` rises, or `frame_err`/`overrun` pulses, on the edge after the stop sample: cycle 4124.
- Back-to-back frames: the next start edge may arrive any time after the stop sample. Minimum frame spacing on the line is 10 bit times.
- Tolerated baud mismatch: ±2% cumulative, given the mid-bit sampling.
- Throughput: one byte per frame. `rx_ready` may be held high permanently.

## Structure
- **Shared package `uart_pkg`:**
  - State encoding localparams (IDLE/START/DATA/STOP, 2-bit).
  - A constant function computing `CLKS_PER_BIT` from `CLK_FREQ`/`BAUD`.
  - Counter width via `$clog2(CLKS_PER_BIT)`.
  - The future transmitter uses the same package.
- **Sub-module `uart_rx_sync`:** 2-flop synchronizer with reset value 1, reusable for `key_0` and other asynchronous inputs.
- **Main module contents:** FSM, baud counter, 3-bit bit counter, shift register, output holding register.

## Test plan
- **Basic byte:** frame 0xA5 at 115200 baud, `rx_ready`=1 → `rx_data`=0xA5 with `rx_valid` high for one cycle, ~4124 cycles after the detected edge; `frame_err`=0.
- **Glitch rejection:** line low for 100 cycles, then high → no `rx_valid`; FSM back in IDLE; a following 0x3C frame is received correctly.
- **Framing error:** frame 0x55 with stop bit low → one `frame_err` pulse, no `rx_valid`. After the line returns high, 0x12 is received correctly.
- **Back-to-back:** 0x00, 0xFF, 0x81 with no idle gap and `rx_ready`=1 → three `rx_valid` pulses in order with the correct data.
- **Overrun / simultaneous accept:**
  - With `rx_ready`=0, send 0x11 then 0x22 → `rx_data` stays 0x11 and `overrun` pulses once.
  - Repeat with `rx_ready` asserted exactly in the completion cycle of 0x22 → `rx_data`=0x22, `rx_valid` stays high, no `overrun`.
- **Reset mid-frame:** assert `rst_n`=0 during data bit 4 of 0xC3 for 100 ns → all outputs 0. A subsequent 0x7E frame is received correctly, with no stale byte.
